// File: rtl/lift_dispatcher_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lift_dispatcher_if
// Brief    : Call-panel / lift handshake bundle for the lift dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface lift_dispatcher_if #(
    parameter int FLOORS = 8,
    parameter int FW     = 3
);
    logic [FLOORS-1:0] call_btn;
    logic              grn;
    logic              red;
    logic              cmd;
    logic [FW-1:0]     cur_floor;
    logic [FW-1:0]     tgt_floor;
    logic              dir_up;
    logic              busy;
    logic [FLOORS-1:0] pending;
    logic              err;

    // Environment side: call panel plus lift controller.
    modport master (
        output call_btn, grn, red,
        input  cmd, cur_floor, tgt_floor, dir_up, busy, pending, err
    );

    // Dispatcher side.
    modport slave (
        input  call_btn, grn, red,
        output cmd, cur_floor, tgt_floor, dir_up, busy, pending, err
    );
endinterface
`default_nettype wire

// File: rtl/lift_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lift_dispatcher
// Brief    : Latches floor calls, picks targets in SCAN order and drives the
//            lift cmd/grn/red handshake while tracking the car position.
// Revision : 1.0 - initial release
// ============================================================================
module lift_dispatcher #(
    parameter int FLOORS     = 8,
    parameter int FW         = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int GRANT_TO   = 6
) (
    input  wire logic        clk,
    input  wire logic        reset,
    lift_dispatcher_if.slave bus
);
    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int GW = (GRANT_TO > 1) ? $clog2(GRANT_TO) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_REQUEST = 3'd2,
        S_MOVE    = 3'd3,
        S_ARRIVE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_q, cmd_d;
    logic [FW-1:0]     cur_floor_q, cur_floor_d;
    logic [FW-1:0]     tgt_floor_q, tgt_floor_d;
    logic              dir_up_q, dir_up_d;
    logic              err_q, err_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]     trv_cnt_q, trv_cnt_d;
    logic [GW-1:0]     gnt_cnt_q, gnt_cnt_d;

    logic              up_found, dn_found;
    logic [FW-1:0]     up_idx, dn_idx;
    logic [FW-1:0]     sel_floor;
    logic              sel_dir_up;
    logic [FW-1:0]     step_floor;
    logic [FLOORS-1:0] clear_mask;

    // Nearest pending call at or above / at or below the car.
    always_comb begin
        up_found = 1'b0;
        up_idx   = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (i >= int'(cur_floor_q))) begin
                up_found = 1'b1;
                up_idx   = FW'(i);
            end
        end
        dn_found = 1'b0;
        dn_idx   = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (i <= int'(cur_floor_q))) begin
                dn_found = 1'b1;
                dn_idx   = FW'(i);
            end
        end
    end

    // Reverse the sweep when nothing remains ahead of the car.
    always_comb begin
        sel_dir_up = dir_up_q;
        sel_floor  = up_idx;
        if (dir_up_q) begin
            if (up_found) begin
                sel_floor = up_idx;
            end else begin
                sel_dir_up = 1'b0;
                sel_floor  = dn_idx;
            end
        end else begin
            if (dn_found) begin
                sel_floor = dn_idx;
            end else begin
                sel_dir_up = 1'b1;
                sel_floor  = up_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cur_floor_d = cur_floor_q;
        tgt_floor_d = tgt_floor_q;
        dir_up_d    = dir_up_q;
        err_d       = err_q;
        trv_cnt_d   = trv_cnt_q;
        gnt_cnt_d   = gnt_cnt_q;
        clear_mask  = '0;
        step_floor  = (tgt_floor_q > cur_floor_q) ? (cur_floor_q + FW'(1))
                                                  : (cur_floor_q - FW'(1));

        case (state_q)
            S_IDLE: begin
                cmd_d = 1'b0;
                if (|pending_q) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                tgt_floor_d = sel_floor;
                dir_up_d    = sel_dir_up;
                gnt_cnt_d   = '0;
                trv_cnt_d   = '0;
                if (sel_floor == cur_floor_q) begin
                    state_d = S_ARRIVE;
                end else begin
                    cmd_d   = 1'b1;
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (bus.grn) begin
                    gnt_cnt_d = '0;
                    state_d   = S_MOVE;
                end else if (gnt_cnt_q == GW'(GRANT_TO - 1)) begin
                    // Pending is untouched, so the call is retried from IDLE.
                    gnt_cnt_d = '0;
                    cmd_d     = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    gnt_cnt_d = gnt_cnt_q + GW'(1);
                end
            end
            S_MOVE: begin
                if (bus.grn) begin
                    if (trv_cnt_q == TW'(TRAVEL_CYC - 1)) begin
                        trv_cnt_d   = '0;
                        cur_floor_d = step_floor;
                        if (step_floor == tgt_floor_q) begin
                            cmd_d   = 1'b0;
                            state_d = S_ARRIVE;
                        end
                    end else begin
                        trv_cnt_d = trv_cnt_q + TW'(1);
                    end
                end
            end
            S_ARRIVE: begin
                cmd_d = 1'b0;
                if (bus.red) begin
                    clear_mask = {{(FLOORS-1){1'b0}}, 1'b1} << tgt_floor_q;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                cmd_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A fresh press for the floor being cleared this cycle is swallowed.
        pending_d = (pending_q | bus.call_btn) & ~clear_mask;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= 1'b0;
            cur_floor_q <= '0;
            tgt_floor_q <= '0;
            dir_up_q    <= 1'b1;
            err_q       <= 1'b0;
            pending_q   <= '0;
            trv_cnt_q   <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cur_floor_q <= cur_floor_d;
            tgt_floor_q <= tgt_floor_d;
            dir_up_q    <= dir_up_d;
            err_q       <= err_d;
            pending_q   <= pending_d;
            trv_cnt_q   <= trv_cnt_d;
            gnt_cnt_q   <= gnt_cnt_d;
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.cur_floor = cur_floor_q;
    assign bus.tgt_floor = tgt_floor_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.pending   = pending_q;
    assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_lift_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lift_dispatcher
// Brief    : Directed bench for lift_dispatcher with a simple lift model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lift_dispatcher;
    localparam int FLOORS     = 8;
    localparam int FW         = 3;
    localparam int TRAVEL_CYC = 4;
    localparam int GRANT_TO   = 6;

    logic clk = 1'b0;
    logic reset;
    bit   grn_en = 1'b1;
    int   hi_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    lift_dispatcher_if #(.FLOORS(FLOORS), .FW(FW)) bus ();

    lift_dispatcher #(
        .FLOORS(FLOORS), .FW(FW), .TRAVEL_CYC(TRAVEL_CYC), .GRANT_TO(GRANT_TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Lift model: grants two cycles after cmd rises, reports stopped once cmd is low.
    always @(negedge clk) begin
        if (bus.cmd === 1'b1) hi_cnt = (hi_cnt < 100) ? hi_cnt + 1 : hi_cnt;
        else                  hi_cnt = 0;
        bus.grn = grn_en && (hi_cnt >= 2);
        bus.red = (bus.cmd !== 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic level, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.busy === level) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.call_btn = 8'($urandom);
            tick();
        end
        checks++; if (bus.cmd !== 1'b0) begin errors++; $display("FAIL rst_cmd got %0b want 0", bus.cmd); end
        checks++; if (bus.cur_floor !== 3'd0) begin errors++; $display("FAIL rst_cur got %0d want 0", bus.cur_floor); end
        checks++; if (bus.tgt_floor !== 3'd0) begin errors++; $display("FAIL rst_tgt got %0d want 0", bus.tgt_floor); end
        checks++; if (bus.dir_up !== 1'b1) begin errors++; $display("FAIL rst_dir got %0b want 1", bus.dir_up); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", bus.busy); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_pending got %h want 00", bus.pending); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", bus.err); end
        reset = 1'b1;
        bus.call_btn = '0;
        tick();
        checks++; if (bus.pending !== 8'h00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_release pending %h busy %0b want 00/0", bus.pending, bus.busy);
        end
    endtask

    task automatic test_single_trip();
        int cmd_cnt = 0, first_cmd = -1, idle_t = -1, nsteps = 0;
        int steps[5];
        logic [FW-1:0] prev;
        bus.call_btn = 8'h20;
        tick();
        bus.call_btn = '0;
        checks++; if (bus.pending !== 8'h20 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL trip_latch pending %h busy %0b want 20/0", bus.pending, bus.busy);
        end
        prev = bus.cur_floor;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (bus.cmd === 1'b1) begin
                cmd_cnt++;
                if (first_cmd < 0) first_cmd = t;
            end
            if (bus.cur_floor !== prev) begin
                if (nsteps < 5) steps[nsteps] = t;
                nsteps++;
                prev = bus.cur_floor;
            end
            if (bus.busy === 1'b0) begin
                idle_t = t;
                break;
            end
        end
        checks++; if (first_cmd != 2) begin errors++; $display("FAIL trip_cmd_rise got %0d want 2", first_cmd); end
        checks++; if (cmd_cnt != 22) begin errors++; $display("FAIL trip_cmd_len got %0d want 22", cmd_cnt); end
        checks++; if (nsteps != 5) begin errors++; $display("FAIL trip_nsteps got %0d want 5", nsteps); end
        for (int k = 0; k < 5 && k < nsteps; k++) begin
            checks++; if (steps[k] != 8 + 4 * k) begin
                errors++; $display("FAIL trip_step%0d got t=%0d want t=%0d", k + 1, steps[k], 8 + 4 * k);
            end
        end
        checks++; if (idle_t != 25) begin errors++; $display("FAIL trip_idle got t=%0d want t=25", idle_t); end
        checks++; if (bus.cur_floor !== 3'd5 || bus.tgt_floor !== 3'd5) begin
            errors++; $display("FAIL trip_final cur %0d tgt %0d want 5/5", bus.cur_floor, bus.tgt_floor);
        end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL trip_clear got %h want 00", bus.pending); end
    endtask

    task automatic test_scan();
        int n;
        bus.call_btn = 8'h84;
        tick();
        bus.call_btn = '0;
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 80, n);
        checks++; if (n < 0) begin errors++; $display("FAIL scan_first_timeout got none want idle"); end
        checks++; if (bus.cur_floor !== 3'd7 || bus.dir_up !== 1'b1 || bus.pending !== 8'h04) begin
            errors++; $display("FAIL scan_first cur %0d dir %0b pend %h want 7/1/04", bus.cur_floor, bus.dir_up, bus.pending);
        end
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 80, n);
        checks++; if (n < 0) begin errors++; $display("FAIL scan_second_timeout got none want idle"); end
        checks++; if (bus.cur_floor !== 3'd2 || bus.dir_up !== 1'b0 || bus.pending !== 8'h00) begin
            errors++; $display("FAIL scan_second cur %0d dir %0b pend %h want 2/0/00", bus.cur_floor, bus.dir_up, bus.pending);
        end
    endtask

    task automatic test_grant_timeout();
        int n, rise_t = -1, fall_t = -1;
        logic err_at_rise = 1'bx;
        grn_en = 1'b0;
        bus.call_btn = 8'h08;
        tick();
        bus.call_btn = '0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (rise_t < 0 && bus.cmd === 1'b1) begin
                rise_t = t;
                err_at_rise = bus.err;
            end else if (rise_t >= 0 && bus.cmd !== 1'b1) begin
                fall_t = t;
                break;
            end
        end
        checks++; if (err_at_rise !== 1'b0) begin errors++; $display("FAIL gto_err_before got %0b want 0", err_at_rise); end
        checks++; if (fall_t - rise_t != GRANT_TO || rise_t < 0) begin
            errors++; $display("FAIL gto_cmd_len got %0d want %0d", fall_t - rise_t, GRANT_TO);
        end
        checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.pending !== 8'h08) begin
            errors++; $display("FAIL gto_abort err %0b busy %0b pend %h want 1/0/08", bus.err, bus.busy, bus.pending);
        end
        checks++; if (bus.dir_up !== 1'b1) begin errors++; $display("FAIL gto_dir got %0b want 1", bus.dir_up); end
        grn_en = 1'b1;
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 40, n);
        checks++; if (n < 0) begin errors++; $display("FAIL gto_retry_timeout got none want idle"); end
        checks++; if (bus.cur_floor !== 3'd3 || bus.err !== 1'b1 || bus.pending !== 8'h00) begin
            errors++; $display("FAIL gto_retry cur %0d err %0b pend %h want 3/1/00", bus.cur_floor, bus.err, bus.pending);
        end
    endtask

    task automatic test_grn_stall();
        int nsteps = 0, arrive_t = -1;
        int steps[2];
        bit seen_cmd = 1'b0;
        logic [FW-1:0] prev;
        bus.call_btn = 8'h20;
        tick();
        bus.call_btn = '0;
        prev = bus.cur_floor;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t == 5) grn_en = 1'b0;
            if (t == 8) grn_en = 1'b1;
            if (bus.cur_floor !== prev) begin
                if (nsteps < 2) steps[nsteps] = t;
                nsteps++;
                prev = bus.cur_floor;
            end
            if (bus.cmd === 1'b1) seen_cmd = 1'b1;
            if (seen_cmd && bus.cmd !== 1'b1) begin
                arrive_t = t;
                // Press the target floor again during the clearing cycle.
                bus.call_btn = 8'h20;
                tick();
                bus.call_btn = '0;
                break;
            end
        end
        checks++; if (nsteps != 2 || steps[0] != 11) begin
            errors++; $display("FAIL stall_step1 got t=%0d want t=11", (nsteps > 0) ? steps[0] : -1);
        end
        checks++; if (nsteps != 2 || steps[1] != 15) begin
            errors++; $display("FAIL stall_step2 got t=%0d want t=15", (nsteps > 1) ? steps[1] : -1);
        end
        checks++; if (arrive_t != 15) begin errors++; $display("FAIL stall_arrive got t=%0d want t=15", arrive_t); end
        checks++; if (bus.pending !== 8'h00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL clear_drop pend %h busy %0b want 00/0", bus.pending, bus.busy);
        end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_no_retrigger busy %0b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_move();
        bit hit = 1'b0;
        bus.call_btn = 8'h01;
        tick();
        bus.call_btn = '0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            bus.call_btn = (t == 10) ? 8'h80 : 8'h00;
            if (bus.cmd === 1'b1 && bus.cur_floor === 3'd2) begin
                hit = 1'b1;
                break;
            end
        end
        bus.call_btn = '0;
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach got none want cur 2 moving"); end
        checks++; if (bus.tgt_floor !== 3'd0 || bus.pending !== 8'h81 || bus.dir_up !== 1'b0 || bus.err !== 1'b1) begin
            errors++; $display("FAIL mid_state tgt %0d pend %h dir %0b err %0b want 0/81/0/1",
                               bus.tgt_floor, bus.pending, bus.dir_up, bus.err);
        end
        reset = 1'b0;
        tick();
        checks++; if (bus.cmd !== 1'b0 || bus.cur_floor !== 3'd0) begin
            errors++; $display("FAIL mid_rst cmd %0b cur %0d want 0/0", bus.cmd, bus.cur_floor);
        end
        checks++; if (bus.pending !== 8'h00 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.dir_up !== 1'b1) begin
            errors++; $display("FAIL mid_rst_state pend %h err %0b busy %0b dir %0b want 00/0/0/1",
                               bus.pending, bus.err, bus.busy, bus.dir_up);
        end
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        bus.call_btn = '0;
        test_reset();
        test_single_trip();
        test_scan();
        test_grant_timeout();
        test_grn_stall();
        test_reset_mid_move();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/lift_dispatcher.md
Name: lift_dispatcher

Overview:
Request-side controller for the lift light controller. It latches floor-call buttons and selects a target floor in SCAN order. It drives the lift's cmd input and waits on grn/red as the grant/stop handshake, tracking the car position with a per-floor travel counter. It sits between the call-button panel and the lift controller instance.

Parameters:
FLOORS, 8, number of floors (2..16); floor indices 0..FLOORS-1
FW, 3, floor index width; must equal ceil(log2(FLOORS))
TRAVEL_CYC, 4, clock cycles per one-floor move (>=1)
GRANT_TO, 6, max cycles to wait for grn after cmd rises (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk
call_btn  input  FLOORS  level/pulse call requests, one bit per floor
grn  input  1  from lift: 1 = go granted
red  input  1  from lift: 1 = stopped
cmd  output  1  to lift: 1 = move requested; registered
cur_floor  output  FW  current car floor
tgt_floor  output  FW  floor being served; valid while busy=1
dir_up  output  1  1 = SCAN direction up
busy  output  1  1 when FSM not in IDLE
pending  output  FLOORS  latched outstanding calls
err  output  1  sticky grant-timeout flag

Behaviour:
- Reset (reset==0 at posedge):
  - cmd=0, cur_floor=0, tgt_floor=0, dir_up=1, busy=0, pending=0, err=0, FSM=IDLE, counters=0.
  - Reset mid-operation aborts immediately; no partial state survives.
- Call latch, every cycle out of reset: pending <= (pending | call_btn) & ~clear_mask.
  - clear_mask is one-hot for tgt_floor only in the ARRIVE->IDLE cycle.
  - A call_btn bit asserted in that same cycle for the same floor is dropped.
  - A call for cur_floor while IDLE is latched, then served at zero distance (see SELECT).
- FSM:
  - IDLE: busy=0, cmd=0. If pending!=0, go to SELECT next cycle.
  - SELECT, 1 cycle, busy=1:
    - If dir_up, pick the lowest pending index >= cur_floor.
    - Else pick the highest pending index <= cur_floor.
    - If none in that direction, toggle dir_up and pick in the new direction in the same cycle.
    - Load tgt_floor.
    - If tgt_floor==cur_floor, go to ARRIVE; else go to REQUEST.
  - REQUEST: cmd=1, grant counter increments each cycle.
    - grn==1 sampled: clear counter, go to MOVE.
    - Counter reaches GRANT_TO with grn==0: cmd=0 next cycle, err<=1, go to IDLE. Pending is kept, so it retries.
  - MOVE: cmd stays 1, travel counter counts 0..TRAVEL_CYC-1.
    - At terminal count: cur_floor steps +1 if tgt>cur, else -1; counter wraps to 0.
    - When the stepped cur_floor equals tgt_floor: cmd<=0, go to ARRIVE.
    - If grn drops during MOVE: travel counter holds (stalls); position does not advance.
  - ARRIVE: cmd=0, wait for red==1.
    - On red==1, clear pending[tgt_floor], go to IDLE.
    - Zero-distance case: red is already 1 after reset, so ARRIVE completes in one cycle.
- Latency: call at floor d from IDLE with grant in g cycles reaches IDLE again in 1 + 1 + g + |d-cur|*TRAVEL_CYC + 1 cycles (minimum), assuming red on the arrival cycle.
- New calls during MOVE are latched only. The target is not re-selected mid-move.
- cur_floor never leaves 0..FLOORS-1. call_btn bits >= FLOORS do not exist.
- err clears only on reset.
- grn and red are both treated as synchronous inputs.

Test Plan:
1. Reset hold 3 cycles with random call_btn -> all outputs 0, dir_up=1, pending=0 after release.
2. FLOORS=8, TRAVEL_CYC=4: pulse call_btn=8'h20 one cycle; model returns grn 2 cycles after cmd and red 1 cycle after cmd falls -> cmd high 2+20 cycles, cur_floor steps 1..5 every 4 cycles, pending[5] clears, busy falls.
3. cur_floor=5, dir_up=1, pending calls at floors 2 and 7 -> serves 7 first, then toggles dir_up=0 and serves 2. Final cur_floor=2, pending=0.
4. grn held 0 with GRANT_TO=6, call at floor 3 -> cmd high exactly 6 cycles, err=1, FSM returns IDLE and retries; later grn=1 completes the trip and err stays 1.
5. grn dropped for 3 cycles mid-MOVE -> cur_floor update delayed by exactly 3 cycles. Also: call_btn for tgt_floor in the clear cycle -> the bit is not retained.
6. reset asserted during MOVE at cur_floor=2 -> next cycle cmd=0, cur_floor=0, pending=0, err=0.
